// File: rtl/reg_scoreboard_if.sv
// Issue / write-back / status bundle between the decode stage and reg_scoreboard.
interface reg_scoreboard_if #(
   parameter int NREG = 32,
   parameter int NWB  = 2
);
   localparam int AW = $clog2(NREG);

   logic              issue_valid;
   logic [AW-1:0]     issue_ra1;
   logic [AW-1:0]     issue_ra2;
   logic              issue_rs1_use;
   logic              issue_rs2_use;
   logic              issue_regwrite;
   logic [AW-1:0]     issue_dst;
   logic              issue_ready;
   logic [NWB-1:0]    wb_valid;
   logic [NWB*AW-1:0] wb_dst;
   logic              flush;
   logic [NREG-1:0]   busy_vec;
   logic [31:0]       stall_cnt;

   modport master (
      output issue_valid, issue_ra1, issue_ra2, issue_rs1_use, issue_rs2_use,
      output issue_regwrite, issue_dst, wb_valid, wb_dst, flush,
      input  issue_ready, busy_vec, stall_cnt
   );

   modport slave (
      input  issue_valid, issue_ra1, issue_ra2, issue_rs1_use, issue_rs2_use,
      input  issue_regwrite, issue_dst, wb_valid, wb_dst, flush,
      output issue_ready, busy_vec, stall_cnt
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-writer counters gating issue on RAW and counter-full hazards.
// Define SCOREBOARD_BYPASS_EN to let a source issue in the same cycle its last pending writer completes.
module reg_scoreboard #(
   parameter int NREG  = 32,
   parameter int NWB   = 2,
   parameter int CNT_W = 2
) (
   input logic             clk,
   input logic             reset,
   reg_scoreboard_if.slave sb
);
   localparam int AW = $clog2(NREG);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count_q [NREG];
   logic [CNT_W-1:0] count_d [NREG];
   logic [31:0]      stall_q;
   logic [31:0]      stall_d;
   logic [NWB-1:0]   wbValid;
   logic [AW-1:0]    wbDst [NWB];
   logic             srcHaz1;
   logic             srcHaz2;
   logic             dstHaz;
   logic             ready;
   logic             fire;

   assign wbValid = sb.wb_valid;

   always_comb begin
      for (int k = 0; k < NWB; k++) begin
         wbDst[k] = sb.wb_dst[k*AW +: AW];
      end
   end

   function automatic logic srcHazard(input logic useSrc, input logic [AW-1:0] ra);
      logic haz;
      haz = useSrc && (ra != '0) && (count_q[ra] != '0);
`ifdef SCOREBOARD_BYPASS_EN
      // The last outstanding writer completing this cycle can be forwarded straight to the reader.
      if (haz && (count_q[ra] == CNT_W'(1))) begin
         for (int k = 0; k < NWB; k++) begin
            if (wbValid[k] && (wbDst[k] == ra)) haz = 1'b0;
         end
      end
`endif
      return haz;
   endfunction

   always_comb begin
      srcHaz1 = srcHazard(sb.issue_rs1_use, sb.issue_ra1);
      srcHaz2 = srcHazard(sb.issue_rs2_use, sb.issue_ra2);
      dstHaz  = sb.issue_regwrite && (sb.issue_dst != '0) && (count_q[sb.issue_dst] == CNT_MAX);
      ready   = !sb.flush && !srcHaz1 && !srcHaz2 && !dstHaz;
      fire    = sb.issue_valid && ready;
   end

   assign sb.issue_ready = ready;
   assign sb.stall_cnt   = stall_q;

   // Net change per register is +issue -completions, floored at zero so late completions of flushed writers vanish.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         int net;
         net = int'(count_q[i]);
         if (fire && sb.issue_regwrite && (int'(sb.issue_dst) == i)) net = net + 1;
         for (int k = 0; k < NWB; k++) begin
            if (wbValid[k] && (int'(wbDst[k]) == i)) net = net - 1;
         end
         if (net < 0) net = 0;
         count_d[i] = ((i == 0) || sb.flush) ? '0 : CNT_W'(net);
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (sb.issue_valid && !ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
   end

   always_comb begin
      sb.busy_vec = '0;
      for (int i = 1; i < NREG; i++) begin
         sb.busy_vec[i] = (count_q[i] != '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) count_q[i] <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) count_q[i] <= count_d[i];
         stall_q <= stall_d;
      end
   end
endmodule
